split_accumulator: RTL and testbench
====================================

SPLIT_ACCUMULATOR -- requirements
Module: split_accumulator

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of the operand counter.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  in  1  operand present.
REQ-005 SHALL have port in_ready  out  1  block accepts operand this cycle.
REQ-006 SHALL have port in_data  in  [0:15]  operand: lane0 = bits [0:7], lane1 = bits [8:15].
REQ-007 SHALL have port in_last  in  1  marks the final operand of a burst; qualified by in_valid.
REQ-008 SHALL have port link  in  1  1 = lanes carry-linked (16-bit add); 0 = two independent 8-bit adds.
REQ-009 SHALL have port clear  in  1  synchronous burst abort.
REQ-010 SHALL have port out_valid  out  1  result available.
REQ-011 SHALL have port out_ready  in  1  consumer takes the result.
REQ-012 SHALL have port out_sum  out  [0:15]  accumulated value, same lane layout as in_data.
REQ-013 SHALL have port out_carry  out  [0:1]  sticky carry-out flags; bit 0 = lane0, bit 1 = lane1.
REQ-014 SHALL have port out_count  out  [CNT_W-1:0]  number of operands accepted in the burst.

Function
REQ-015 Operand transfer SHALL occur only on a cycle with in_valid=1 and in_ready=1; result transfer SHALL occur only on a cycle with out_valid=1 and out_ready=1.
REQ-016 Within a lane, bit 0/8 SHALL be the MSB. Lane0 SHALL be the low-order byte: in linked mode, the lane0 carry-out feeds the lane1 carry-in.
REQ-017 Lane sums SHALL wrap modulo 256 in split mode and modulo 65536 in linked mode; there is no saturation.
REQ-018 The FSM SHALL have 3 states: IDLE, ACC and HOLD.
REQ-019 IDLE: in_ready=1. On transfer: acc<=in_data, count<=1, out_carry<=00, link_r<=link; go to HOLD if in_last=1, else go to ACC.
REQ-020 ACC: in_ready=1. On transfer: acc<=acc+in_data using link_r; count<=count+1, saturating at 2^CNT_W-1; go to HOLD if in_last=1.
REQ-021 Carry flags SHALL be OR-accumulated. In split mode, each lane sets its own flag. In linked mode, only the lane1 carry-out sets out_carry[1], and out_carry[0] stays 0.
REQ-022 link SHALL be sampled only on the first operand of a burst; changes to link later in the burst SHALL be ignored.
REQ-023 HOLD: out_valid=1, in_ready=0, and out_sum/out_carry/out_count SHALL be stable. On result transfer, go to IDLE; out_valid is 0 on the next cycle.
REQ-024 Latency: out_valid SHALL assert on the first cycle after the in_last operand transfer.
REQ-025 The cycle after a HOLD release SHALL be IDLE; the minimum burst-to-burst gap is therefore 1 cycle.
REQ-026 in_ready SHALL be combinational, equal to (state != HOLD) and !clear.
REQ-027 clear=1 SHALL take priority over all other events and SHALL act in any state: the next state is IDLE, and acc/count/out_carry are zeroed. An operand presented in the same cycle is not accepted. A result held in HOLD is discarded.
REQ-028 In ACC with in_valid=0, state and registers SHALL be held.
REQ-029 out_sum, out_carry and out_count SHALL be driven directly from registers at all times. Their values are defined for the consumer only while out_valid=1.

Reset
REQ-030 When rst_n=0, the block SHALL immediately, without waiting for clk, force: state IDLE, acc 0x0000, out_carry 00, count 0, link_r 0, out_valid 0.
REQ-031 in_ready SHALL be 0 while rst_n=0 and SHALL be 1 on the first cycle after release.
REQ-032 Reset asserted mid-burst or in HOLD SHALL discard all partial or pending results.

Verification
REQ-033 Linked carry: link=1; operands lane0/lane1 = FF/00 then 01/00 (last) -> out_sum lanes 00/01, out_carry=00, out_count=2, out_valid on the cycle after the 2nd transfer.
REQ-034 Split isolation: link=0; same two operands -> lanes 00/00, out_carry=01 (lane0 flag only), out_count=2.
REQ-035 Linked overflow with mid-burst link change: link=1 on operand 1 (FF/FF), link=0 on operand 2 (01/00, last) -> lanes 00/00, out_carry=10 (bit 1 set), linked mode still used.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid stays 1, in_ready stays 0, outputs unchanged, no operand accepted. Raise out_ready -> out_valid=0 and in_ready=1 on the next cycle.
REQ-037 Clear: after 2 operands accepted, pulse clear with in_valid=1 -> that operand is not accepted and state returns to IDLE. A following single-operand burst of 0x1234 -> out_sum 0x1234, out_count=1, out_carry=00.
REQ-038 Async reset in HOLD plus saturation: 16 operands of 00/01 -> out_count=15 (saturated), lanes 00/10. Then drop rst_n between clock edges -> out_valid=0 immediately, out_sum=0x0000.

Source files
------------

// File: rtl/split_accumulator_if.sv
// rtl/split_accumulator_if.sv - operand/result stream bundle for split_accumulator
interface split_accumulator_if #(
    parameter int CNT_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [0:15]      in_data;
    logic             in_last;
    logic             link;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [0:15]      out_sum;
    logic [0:1]       out_carry;
    logic [CNT_W-1:0] out_count;

    modport slave (
        input  in_valid, in_data, in_last, link, clear, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_count
    );

    modport master (
        output in_valid, in_data, in_last, link, clear, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_count
    );
endinterface

// File: rtl/split_accumulator.sv
// rtl/split_accumulator.sv - two-lane byte accumulator, optionally carry-linked into one 16-bit add
module split_accumulator #(
    parameter int CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    split_accumulator_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [1:0]       carry_q, carry_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             link_q, link_d;

    logic             in_ready;
    logic             accept;
    logic [7:0]       din0, din1;
    logic [8:0]       sum0, sum1;
    logic             cin1;

    // Lane0 sits in bits [0:7] (MSB at bit 0) and is the low-order byte.
    assign din0 = bus.in_data[0:7];
    assign din1 = bus.in_data[8:15];

    assign sum0 = {1'b0, acc_q[7:0]} + {1'b0, din0};
    assign cin1 = link_q & sum0[8];
    assign sum1 = {1'b0, acc_q[15:8]} + {1'b0, din1} + {8'd0, cin1};

    assign in_ready = rst_n && (state_q != HOLD) && !bus.clear;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        count_d = count_q;
        link_d  = link_q;
        if (bus.clear) begin
            state_d = IDLE;
            acc_d   = '0;
            carry_d = '0;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d   = {din1, din0};
                        count_d = CNT_W'(1);
                        carry_d = '0;
                        link_d  = bus.link;
                        state_d = bus.in_last ? HOLD : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc_d   = {sum1[7:0], sum0[7:0]};
                        // A linked lane0 carry is internal; only lane1 reports overflow.
                        carry_d = carry_q | {sum1[8], sum0[8] & ~link_q};
                        count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                        if (bus.in_last) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            carry_q <= '0;
            count_q <= '0;
            link_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            count_q <= count_d;
            link_q  <= link_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = (state_q == HOLD);
    assign bus.out_sum[0:7] = acc_q[7:0];
    assign bus.out_sum[8:15] = acc_q[15:8];
    assign bus.out_carry[0] = carry_q[0];
    assign bus.out_carry[1] = carry_q[1];
    assign bus.out_count    = count_q;
endmodule

// File: tb/tb_split_accumulator.sv
// tb/tb_split_accumulator.sv - randomized and directed checks of split_accumulator against an arithmetic model
module tb_split_accumulator;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    split_accumulator_if #(.CNT_W(CNT_W)) bus ();

    split_accumulator #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference: burst value as plain integers, first operand fixes the mode.
    int msum;
    int mcnt;
    bit mc0, mc1, mlink;
    bit mfirst = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_push(input int l0, input int l1, input bit lk);
        int t, s0, s1;
        if (mfirst) begin
            msum   = l1 * 256 + l0;
            mcnt   = 1;
            mc0    = 1'b0;
            mc1    = 1'b0;
            mlink  = lk;
            mfirst = 1'b0;
        end else begin
            if (mlink) begin
                t = msum + l1 * 256 + l0;
                if (t >= 65536) mc1 = 1'b1;
                msum = t % 65536;
            end else begin
                s0 = (msum % 256) + l0;
                s1 = (msum / 256) + l1;
                if (s0 >= 256) mc0 = 1'b1;
                if (s1 >= 256) mc1 = 1'b1;
                msum = (s1 % 256) * 256 + (s0 % 256);
            end
            mcnt = (mcnt + 1 > CMAX) ? CMAX : mcnt + 1;
        end
    endtask

    task automatic send_op(input logic [7:0] l0, input logic [7:0] l1, input logic lst,
                           input logic lk, input int gap);
        logic [0:15] d;
        int b;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        d = {l0, l1};
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = lst;
        bus.link     = lk;
        b = 0;
        @(negedge clk);
        while (!bus.in_ready && b < 64) begin
            @(negedge clk);
            b++;
        end
        chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.link     = $urandom_range(0, 1);
        model_push(int'(l0), int'(l1), lk);
        if (lst) chk("latency_valid", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_sum"},   32'({bus.out_sum[8:15], bus.out_sum[0:7]}), 32'(msum));
        chk({tag, "_carry"}, 32'({bus.out_carry[1], bus.out_carry[0]}), 32'({mc1, mc0}));
        chk({tag, "_count"}, 32'(bus.out_count), 32'(mcnt));
    endtask

    task automatic take_result(input int delay);
        repeat (delay) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("release_valid", 32'(bus.out_valid), 32'd0);
        chk("release_ready", 32'(bus.in_ready), 32'd1);
        mfirst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:15] saved;
        int n;
        bit lk;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.link      = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_in_ready",  32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum",       32'(bus.out_sum), 32'd0);
        chk("rst_count",     32'(bus.out_count), 32'd0);
        chk("rst_carry",     32'(bus.out_carry), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

        // Linked carry
        send_op(8'hFF, 8'h00, 1'b0, 1'b1, 0);
        send_op(8'h01, 8'h00, 1'b1, 1'b1, 0);
        chk("link_lane0", 32'(bus.out_sum[0:7]), 32'h00);
        chk("link_lane1", 32'(bus.out_sum[8:15]), 32'h01);
        chk("link_carry", 32'({bus.out_carry[1], bus.out_carry[0]}), 32'd0);
        chk("link_count", 32'(bus.out_count), 32'd2);
        check_model("link");
        take_result(0);

        // Split isolation
        send_op(8'hFF, 8'h00, 1'b0, 1'b0, 1);
        send_op(8'h01, 8'h00, 1'b1, 1'b0, 0);
        chk("split_lane0", 32'(bus.out_sum[0:7]), 32'h00);
        chk("split_lane1", 32'(bus.out_sum[8:15]), 32'h00);
        chk("split_c0",    32'(bus.out_carry[0]), 32'd1);
        chk("split_c1",    32'(bus.out_carry[1]), 32'd0);
        chk("split_count", 32'(bus.out_count), 32'd2);
        take_result(1);

        // Linked overflow, link dropped mid-burst
        send_op(8'hFF, 8'hFF, 1'b0, 1'b1, 0);
        send_op(8'h01, 8'h00, 1'b1, 1'b0, 0);
        chk("ovf_sum", 32'(bus.out_sum), 32'h0000);
        chk("ovf_c0",  32'(bus.out_carry[0]), 32'd0);
        chk("ovf_c1",  32'(bus.out_carry[1]), 32'd1);
        check_model("ovf");

        // Backpressure with a competing operand
        saved = bus.out_sum;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hAAAA;
        bus.in_last  = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_sum",   32'(bus.out_sum), 32'(saved));
            chk("bp_count", 32'(bus.out_count), 32'd2);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        chk("bp_rel_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_rel_ready", 32'(bus.in_ready), 32'd1);
        mfirst = 1'b1;

        // Clear mid-burst
        send_op(8'h11, 8'h22, 1'b0, 1'b0, 0);
        send_op(8'h33, 8'h44, 1'b0, 1'b0, 0);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hBEEF;
        @(negedge clk);
        chk("clr_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_valid", 32'(bus.out_valid), 32'd0);
        chk("clr_count", 32'(bus.out_count), 32'd0);
        chk("clr_sum",   32'(bus.out_sum), 32'd0);
        mfirst = 1'b1;
        send_op(8'h12, 8'h34, 1'b1, 1'($urandom_range(0, 1)), 0);
        chk("clr_next_sum",   32'(bus.out_sum), 32'h1234);
        chk("clr_next_count", 32'(bus.out_count), 32'd1);
        chk("clr_next_carry", 32'(bus.out_carry), 32'd0);
        take_result(0);

        // Count saturation, then async reset while holding
        lk = 1'($urandom_range(0, 1));
        for (int i = 0; i < 16; i++) begin
            send_op(8'h00, 8'h01, 1'(i == 15), lk, 0);
        end
        chk("sat_count", 32'(bus.out_count), 32'(CMAX));
        chk("sat_lane0", 32'(bus.out_sum[0:7]), 32'h00);
        chk("sat_lane1", 32'(bus.out_sum[8:15]), 32'h10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_sum",   32'(bus.out_sum), 32'd0);
        chk("arst_ready", 32'(bus.in_ready), 32'd0);
        chk("arst_count", 32'(bus.out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_rel_ready", 32'(bus.in_ready), 32'd1);
        mfirst = 1'b1;

        // Randomized bursts
        for (int b = 0; b < 40; b++) begin
            n  = $urandom_range(1, 20);
            lk = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                send_op(8'($urandom), 8'($urandom), 1'(i == n - 1),
                        (i == 0) ? lk : 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            end
            check_model("rnd");
            take_result($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
